mem_port_arbiter: RTL and testbench

- Multi-cycle controller that shares one single-port synchronous memory between instruction fetch and the load/store path of the RV32I core.
- Arbitrates between the two requesters and sequences each transaction: issue, wait for read latency, respond.
- Generates the core stall signal.
- Data requests have priority, with a starvation guard for fetch.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between
// instruction fetch and load/store. Data requests win arbitration unless
// fetch has lost STARVE_LIM consecutive contested rounds.
// Ports: clk, rst (async, active high); fetch side if_req/if_addr ->
// if_rdata/if_valid; data side d_req/d_we/d_addr/d_wdata/d_be ->
// d_rdata/d_valid; memory side mem_en/mem_we/mem_addr/mem_wdata/mem_be
// with mem_rdata valid MEM_LAT cycles after a read strobe; stall to core.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);
  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_t     state;
  state_t     state_n;
  logic [3:0] starve_cnt;
  logic [2:0] wait_cnt;
  logic       owner_d;
  logic       grant_d;
  logic       grant_f;

  assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

  always_comb begin
    state_n = state;
    grant_d = 1'b0;
    grant_f = 1'b0;
    unique case (state)
      IDLE: begin
        grant_d = d_req & ~(if_req & (starve_cnt >= LIM));
        grant_f = if_req & ~grant_d;
        if (grant_d | grant_f) state_n = ISSUE;
      end
      ISSUE: state_n = mem_we ? RESP : WAIT;
      WAIT: if (wait_cnt == 3'd1) state_n = RESP;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Counts contested rounds lost by fetch; any fetch win clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_f) begin
      starve_cnt <= '0;
    end else if (grant_d & if_req & (starve_cnt != 4'hF)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // The mem_* registers double as the latched transaction, so they
  // naturally hold their values through WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_d   <= 1'b0;
      wait_cnt  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_d) begin
            owner_d   <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr & ~32'h3;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
          end else if (grant_f) begin
            owner_d   <= 1'b0;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr & ~32'h3;
            mem_wdata <= '0;
            mem_be    <= 4'hF;
          end
        end
        ISSUE: begin
          mem_en   <= 1'b0;
          wait_cnt <= LAT;
          if (mem_we) begin
            d_valid  <= owner_d;
            if_valid <= ~owner_d;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            if (owner_d) d_rdata  <= mem_rdata;
            else         if_rdata <= mem_rdata;
            d_valid  <= owner_d;
            if_valid <= ~owner_d;
          end
        end
        RESP: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table, multi-cycle corner sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int SLIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        stall;

  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_LIM(SLIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  always #5 clk = ~clk;

  // Synchronous memory with LAT-cycle read pipeline; idle slots carry junk.
  logic [31:0] mem [256];
  logic [31:0] pipe [LAT];
  logic        mem_load = 1'b1;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | i;
      mem[4] <= 32'h0000_0013;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[9:2]] : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign mem_rdata = pipe[LAT-1];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    bit          f;
    bit          we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] ea;
    logic [31:0] er;
  } vec_t;

  vec_t tbl [10];

  task automatic txn(input vec_t v, input int idx);
    int ev;
    int vc;
    int nv;
    logic vl;
    ev = v.we ? 2 : 2 + LAT;
    vc = -1;
    nv = 0;
    @(posedge clk); #1;
    if (v.f) begin
      if_req = 1'b1; if_addr = v.a;
    end else begin
      d_req = 1'b1; d_we = v.we; d_addr = v.a;
      d_wdata = v.wd; d_be = v.be;
    end
    @(negedge clk);
    chk($sformatf("v%0d stall c0", idx), 32'(stall), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk($sformatf("v%0d mem_en", idx), 32'(mem_en), 32'd1);
        chk($sformatf("v%0d mem_addr", idx), mem_addr, v.ea);
        chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.we));
        chk($sformatf("v%0d mem_be", idx), 32'(mem_be),
            v.f ? 32'hF : 32'(v.be));
        chk($sformatf("v%0d mem_wdata", idx), mem_wdata,
            v.f ? 32'h0 : v.wd);
      end
      if (k <= ev)
        chk($sformatf("v%0d stall c%0d", idx, k), 32'(stall), 32'(k < ev));
      vl = v.f ? if_valid : d_valid;
      if (vl) begin
        nv++;
        if (vc < 0) vc = k;
        @(posedge clk); #1;
        if_req = 1'b0;
        d_req = 1'b0;
      end
    end
    chk($sformatf("v%0d valid cycle", idx), 32'(vc), 32'(ev));
    chk($sformatf("v%0d valid count", idx), 32'(nv), 32'd1);
    if (!v.we)
      chk($sformatf("v%0d rdata", idx), v.f ? if_rdata : d_rdata, v.er);
    if (!v.f)
      chk($sformatf("v%0d if_rdata kept", idx), if_rdata, 32'h13);
  endtask

  logic [31:0] ref_mem [256];
  int   g, iv, di, dv, nv, n_en;
  bit   iseen, dseen;
  logic [9:0] order;
  int   free_from, exp_issue, exp_valid, starve;
  bit   e_d, e_we, i_act, d_act, i_done, d_done, fw;
  logic [31:0] e_addr, e_wd, e_rd;
  logic [3:0]  e_be;

  initial begin
    tbl[0] = '{1, 0, 32'h10,  32'h0,         4'hF, 32'h10,  32'h13};
    tbl[1] = '{0, 1, 32'h102, 32'h00AB_0000, 4'h4, 32'h100, 32'h0};
    tbl[2] = '{0, 0, 32'h101, 32'h0,         4'hF, 32'h100, 32'hC0AB_0040};
    tbl[3] = '{0, 1, 32'h20,  32'h1234_5678, 4'hF, 32'h20,  32'h0};
    tbl[4] = '{0, 0, 32'h23,  32'h0,         4'hF, 32'h20,  32'h1234_5678};
    tbl[5] = '{0, 1, 32'h3FF, 32'hAA00_00BB, 4'h9, 32'h3FC, 32'h0};
    tbl[6] = '{0, 0, 32'h3FC, 32'h0,         4'hF, 32'h3FC, 32'hAADE_00BB};
    tbl[7] = '{0, 1, 32'h0,   32'hFFFF_FFFF, 4'h0, 32'h0,   32'h0};
    tbl[8] = '{0, 0, 32'h2,   32'h0,         4'hF, 32'h0,   32'hC0DE_0000};
    tbl[9] = '{1, 0, 32'h3FD, 32'h0,         4'hF, 32'h3FC, 32'hAADE_00BB};

    // Reset state
    @(posedge clk); #1;
    mem_load = 1'b0;
    @(negedge clk);
    chk("rst mem_en", 32'(mem_en), 32'd0);
    chk("rst valids", {30'd0, if_valid, d_valid}, 32'd0);
    chk("rst rdata", if_rdata | d_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post rst outs",
        mem_addr | mem_wdata | 32'({mem_en, mem_we, mem_be}), 32'd0);
    chk("post rst stall", 32'(stall), 32'd0);

    for (int i = 0; i < 10; i++) txn(tbl[i], i);

    // Both requesters held: fetch wins every (SLIM+1)th grant
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_be = 4'hF;
    g = 0;
    order = '0;
    for (int k = 0; k < 200 && g < 10; k++) begin
      @(negedge clk);
      if (mem_en) begin
        order[g] = (mem_addr == 32'h10);
        g++;
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    repeat (12) @(posedge clk);
    chk("starve grants", 32'(g), 32'd10);
    chk("starve order", 32'(order), 32'h210);

    // Load requested while fetch waits
    iv = -1; di = -1; dv = -1; iseen = 0; dseen = 0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin if_req = 1'b1; if_addr = 32'h10; end
      if (k == 2) begin
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_be = 4'hF;
      end
      if (iseen) if_req = 1'b0;
      if (dseen) d_req = 1'b0;
      @(negedge clk);
      iseen = if_valid;
      dseen = d_valid;
      if (if_valid && iv < 0) iv = k;
      if (d_valid && dv < 0) dv = k;
      if (mem_en && mem_addr == 32'h20 && di < 0) di = k;
    end
    chk("busy if_valid cyc", 32'(iv), 32'(2 + LAT));
    chk("busy d issue cyc", 32'(di), 32'(4 + LAT));
    chk("busy d_valid cyc", 32'(dv), 32'(5 + 2 * LAT));
    chk("busy d_rdata", d_rdata, 32'h1234_5678);
    chk("busy if_rdata", if_rdata, 32'h13);

    // Asynchronous reset during a load's WAIT
    nv = 0; dv = -1; dseen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
      end
      if (k == 2) begin
        rst = 1'b1;
        #1;
        chk("async mem_addr", mem_addr, 32'd0);
        chk("async rdata", {if_rdata[15:0], d_rdata[15:0]}, 32'd0);
        chk("async ctl", 32'({mem_en, mem_we, mem_be, if_valid, d_valid}),
            32'd0);
        chk("async wdata", mem_wdata, 32'd0);
      end
      if (k == 4) rst = 1'b0;
      if (dseen) d_req = 1'b0;
      @(negedge clk);
      dseen = d_valid;
      if (d_valid) begin
        nv++;
        if (dv < 0) dv = k;
      end
    end
    chk("rst-load valids", 32'(nv), 32'd1);
    chk("rst-load cycle", 32'(dv), 32'(6 + LAT));
    chk("rst-load rdata", d_rdata, 32'hC0AB_0040);

    // Request withdrawn right after arbitration
    nv = 0; dv = -1; n_en = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3FC; d_be = 4'hF;
      end
      if (k == 1) d_req = 1'b0;
      @(negedge clk);
      if (mem_en) n_en++;
      if (d_valid) begin
        nv++;
        if (dv < 0) dv = k;
      end
    end
    chk("drop valids", 32'(nv), 32'd1);
    chk("drop cycle", 32'(dv), 32'(2 + LAT));
    chk("drop strobes", 32'(n_en), 32'd1);
    chk("drop rdata", d_rdata, 32'hAADE_00BB);

    // Randomized traffic against a transaction-level model
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    free_from = 0; exp_issue = -1; exp_valid = -1; starve = 0;
    i_act = 0; d_act = 0; i_done = 0; d_done = 0;
    e_d = 0; e_we = 0; e_addr = '0; e_wd = '0; e_be = '0; e_rd = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (i_done) begin if_req = 1'b0; i_act = 0; end
      if (d_done) begin d_req = 1'b0; d_act = 0; end
      if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1; if_req = 1'b1;
        if_addr = 32'($urandom_range(0, 1023));
      end
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1; d_req = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 1023));
        d_wdata = $urandom;
        d_be = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      chk("rnd mem_en", 32'(mem_en), 32'(cyc == exp_issue));
      if (cyc == exp_issue) begin
        chk("rnd mem_addr", mem_addr, e_addr);
        chk("rnd mem_we", 32'(mem_we), 32'(e_we));
        chk("rnd mem_be", 32'(mem_be), 32'(e_be));
        chk("rnd mem_wdata", mem_wdata, e_wd);
        if (e_we) begin
          for (int b = 0; b < 4; b++)
            if (e_be[b]) ref_mem[e_addr[9:2]][8*b +: 8] = e_wd[8*b +: 8];
        end else begin
          e_rd = ref_mem[e_addr[9:2]];
        end
      end
      chk("rnd if_valid", 32'(if_valid), 32'(cyc == exp_valid && !e_d));
      chk("rnd d_valid", 32'(d_valid), 32'(cyc == exp_valid && e_d));
      if (cyc == exp_valid && !e_we)
        chk("rnd rdata", e_d ? d_rdata : if_rdata, e_rd);
      chk("rnd stall", 32'(stall),
          32'((if_req && !if_valid) || (d_req && !d_valid)));
      i_done = if_valid;
      d_done = d_valid;
      if (cyc >= free_from && (if_req || d_req)) begin
        fw = if_req && (!d_req || starve >= SLIM);
        if (fw) begin
          e_d = 0; e_we = 0; e_addr = if_addr & 32'hFFFF_FFFC;
          e_be = 4'hF; e_wd = '0; starve = 0;
        end else begin
          e_d = 1; e_we = d_we; e_addr = d_addr & 32'hFFFF_FFFC;
          e_be = d_be; e_wd = d_wdata;
          if (if_req) starve = (starve < 15) ? starve + 1 : 15;
        end
        exp_issue = cyc + 1;
        exp_valid = cyc + 2 + (e_we ? 0 : LAT);
        free_from = exp_valid + 1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
